// File: rtl/lsu_mem_port_if.sv
// Request, response and memory-port signals of the load/store unit, bundled
// as one interface. The master modport is the LSU itself (it answers
// requests and drives the memory port). The slave modport is the
// environment: the CPU execute stage plus the memory.
interface lsu_mem_port_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BYTES_W = $clog2(DATA_WIDTH / 8) + 1;

    // Request channel from the execute stage
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_store;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    // Response channel back to the execute stage
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    // Data-side memory port
    logic [ADDR_WIDTH-1:0] mem_fetch_addr;
    logic [DATA_WIDTH-1:0] mem_fetched_data;
    logic [BYTES_W-1:0]    mem_bytes_to_write;
    logic [ADDR_WIDTH-1:0] mem_write_addr;
    logic [DATA_WIDTH-1:0] mem_write_data;

    modport master (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output mem_fetch_addr, mem_bytes_to_write, mem_write_addr, mem_write_data,
        input  mem_fetched_data
    );

    modport slave (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  mem_fetch_addr, mem_bytes_to_write, mem_write_addr, mem_write_data,
        output mem_fetched_data
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store initiator between the CPU execute stage and the data side of the
// unified byte-addressed, little-endian memory.
// Each request runs IDLE -> ISSUE -> RESP:
//   - A store raises the write strobe during its single ISSUE cycle.
//   - A load registers the extended fetch data at the edge that ends ISSUE.
// Optional macro LSU_MISALIGN_TRAP_EN: when it is defined, misaligned half and
// word accesses are reported as errors instead of being performed.
// DATA_WIDTH must be 32, because access sizes are byte, half and word.
module lsu_mem_port #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    lsu_mem_port_if.master bus
);
    localparam int BYTES_W = $clog2(DATA_WIDTH / 8) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                state, state_next;

    // Request fields captured on acceptance
    logic                  lat_store;
    logic [1:0]            lat_size;
    logic                  lat_unsigned;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic                  accept;
    logic                  access_err;

    // Sign- or zero-extend the low 1/2/4 bytes of the fetched word
    function automatic logic [DATA_WIDTH-1:0] extend_load(
        input logic [DATA_WIDTH-1:0] d,
        input logic [1:0]            size,
        input logic                  uns
    );
        logic [DATA_WIDTH-1:0] r;
        r = d;
        case (size)
            2'd0:    r = uns ? {{(DATA_WIDTH-8){1'b0}}, d[7:0]}
                         : {{(DATA_WIDTH-8){d[7]}}, d[7:0]};
            2'd1:    r = uns ? {{(DATA_WIDTH-16){1'b0}}, d[15:0]}
                         : {{(DATA_WIDTH-16){d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // The reserved size is always an error. Misalignment is an error only
    // when the trap is built in; otherwise the byte-addressed memory handles it.
`ifdef LSU_MISALIGN_TRAP_EN
    assign access_err = (lat_size == 2'd3)
                      || (lat_size == 2'd1 && lat_addr[0] != 1'b0)
                      || (lat_size == 2'd2 && lat_addr[1:0] != 2'b00);
`else
    assign access_err = (lat_size == 2'd3);
`endif

    // req_ready is gated by rst because the state already reads IDLE during reset
    assign bus.req_ready = !rst && ((state == IDLE) || (state == RESP && bus.resp_ready));
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = (state == RESP);

    // Addresses are passed through unmodified; wrap-around belongs to the memory
    assign bus.mem_fetch_addr = lat_addr;
    assign bus.mem_write_addr = lat_addr;
    assign bus.mem_write_data = lat_wdata;

    // Write strobe: 1 << size only in ISSUE of a legal store. Because it is
    // combinational on state, it drops as soon as the async reset hits.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        bus.mem_bytes_to_write = '0;
        if (state == ISSUE && lat_store && !access_err)
            bus.mem_bytes_to_write = {{(BYTES_W-1){1'b0}}, 1'b1} << lat_size;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.req_valid) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    if (bus.resp_ready) state_next = bus.req_valid ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture request fields whenever a request is accepted
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: these are plain flops, not a memory, so they are reset to keep the outputs at zero.
        if (rst) begin
            lat_store    <= 1'b0;
            lat_size     <= 2'd0;
            lat_unsigned <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
        end else if (accept) begin
            lat_store    <= bus.req_store;
            lat_size     <= bus.req_size;
            lat_unsigned <= bus.req_unsigned;
            lat_addr     <= bus.req_addr;
            lat_wdata    <= bus.req_wdata;
        end
    end

    // Register the response at the end of ISSUE; it holds unchanged through RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else if (state == ISSUE) begin
            bus.resp_err   <= access_err;
            bus.resp_rdata <= (lat_store || access_err) ? '0
                            : extend_load(bus.mem_fetched_data, lat_size, lat_unsigned);
        end
    end
endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store initiator between the CPU execute stage and the data-side port of the unified byte-addressed memory (fetch/write side, not the instruction side).
- Accepts one load or store request per valid/ready handshake.
- Stores: drives the memory write strobes for exactly one cycle. Loads: samples the combinational fetch data, sign- or zero-extends it, and returns it over a valid/ready response channel.
- Memory is little-endian: byte at addr+i occupies data bits [8i+7:8i].

Parameters:
ADDR_WIDTH, 32, address width, matches memory.
DATA_WIDTH, 32, data width, matches memory; must be 32 (sizes are byte/half/word).
BYTES_W, $clog2(DATA_WIDTH/8)+1 (localparam), width of mem_bytes_to_write.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  request accepted when valid&ready at clk edge
req_store  input  1  1=store, 0=load
req_size  input  2  0=byte, 1=half, 2=word, 3=reserved
req_unsigned  input  1  load zero-extend when 1, sign-extend when 0
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  DATA_WIDTH  store data, low bytes used
resp_valid  output  1  response present
resp_ready  input  1  response consumed when valid&ready at clk edge
resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors
resp_err  output  1  access error (reserved size, or misalignment with feature on)
mem_fetch_addr  output  ADDR_WIDTH  to memory fetch_addr
mem_fetched_data  input  DATA_WIDTH  from memory fetched_data (combinational)
mem_bytes_to_write  output  BYTES_W  to memory bytes_to_write; 0 = no-op
mem_write_addr  output  ADDR_WIDTH  to memory write_addr
mem_write_data  output  DATA_WIDTH  to memory write_data

Behaviour:
- Reset (async, immediate on rst high):
  - FSM enters IDLE.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_bytes_to_write=0; all address/data outputs 0.
  - req_ready=0 while rst is high.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: req_ready=1. On req_valid, latch store/size/unsigned/addr/wdata; go to ISSUE.
  - ISSUE (exactly one cycle, req_ready=0):
    - mem_fetch_addr = mem_write_addr = latched addr, passed unmodified; wrap-around above 2^ADDR_WIDTH is the memory's concern.
    - Store with legal size: mem_bytes_to_write = 1<<size (1/2/4), mem_write_data = latched wdata. Otherwise mem_bytes_to_write=0.
    - Load: at the ISSUE-ending edge, register mem_fetched_data[8*(1<<size)-1:0], extended per req_unsigned, into resp_rdata.
    - Go to RESP.
  - RESP: resp_valid=1; resp_rdata/resp_err stable until handshake.
    - req_ready = resp_ready.
    - On resp_ready with req_valid: latch the new request, go to ISSUE (back-to-back; throughput one op per 2 cycles).
    - On resp_ready without req_valid: go to IDLE.
    - No resp_ready: hold.
- Latency: request accepted at edge N; store commits at edge N+1; resp_valid high from edge N+1.
- mem_bytes_to_write is nonzero only in the ISSUE state of a legal store. Never nonzero in IDLE, RESP, or during reset.
- Stores return a response with resp_rdata=0.
- req_size=3: no memory write; resp_rdata=0, resp_err=1; same latency.
- Reset asserted during ISSUE: strobe drops immediately, so no partial write is claimed. Any pending response is discarded.
- Request inputs are ignored when req_ready=0.

Optional Feature:
Macro LSU_MISALIGN_TRAP_EN.
- Defined: half with addr[0]!=0, or word with addr[1:0]!=0, is an error. No write strobe; resp_rdata=0, resp_err=1; same FSM path and latency.
- Undefined: misaligned accesses proceed normally, since the memory is byte-addressed. resp_err is set only for size 3.

Test Plan:
- Store word 0xDEADBEEF @0x20, then load word unsigned @0x20 -> strobe=4 for one cycle; load resp_rdata=0xDEADBEEF, err=0.
- Memory byte @0x10=0x80: load byte signed -> 0xFFFFFF80; load byte unsigned -> 0x00000080; load half signed @0x10 with @0x11=0x7F -> 0x00007F80.
- Store half 0x12345678 @0x31 -> bytes 0x31=0x78, 0x32=0x56, 0x30/0x33 unchanged. With LSU_MISALIGN_TRAP_EN: no write, resp_err=1.
- Hold resp_ready=0 for 5 cycles after a load: resp_valid, resp_rdata stay stable, req_ready=0. Then resp_ready=1 with req_valid=1: next request accepted same edge, ISSUE the following cycle.
- req_size=3 store @0x40 -> mem_bytes_to_write stays 0; resp_err=1, resp_rdata=0.
- Assert rst asynchronously mid-ISSUE of a store -> mem_bytes_to_write=0 and resp_valid=0 before the next edge. After release, req_ready=1 in IDLE.
